// File: rtl/wb_stream_port_pkg.sv
// Shared definitions for the Wishbone stream port: register indices, STATUS
// bit positions and the STATUS word packing helper.
package wb_stream_port_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_RSVD2  = 2'd2,
    REG_RSVD3  = 2'd3
  } regIdx_e;

  localparam int ST_RX_NE    = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_TX_FULL  = 2;
  localparam int ST_TX_OVF   = 4;

  function automatic logic [31:0] packStatus(
    input logic txOvf,
    input logic txFull,
    input logic txEmpty,
    input logic rxNonEmpty
  );
    logic [31:0] v;
    v              = '0;
    v[ST_TX_OVF]   = txOvf;
    v[ST_TX_FULL]  = txFull;
    v[ST_TX_EMPTY] = txEmpty;
    v[ST_RX_NE]    = rxNonEmpty;
    return v;
  endfunction

endpackage

// File: rtl/wb_stream_port_fifo.sv
// Show-ahead synchronous FIFO; a push while full and a pop while empty are
// both ignored, judged from the registered count.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [WIDTH-1:0]      i_data,
  output logic [WIDTH-1:0]      o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pushOk;
  logic                  w_popOk;

  assign w_full   = (r_count == FULL_COUNT);
  assign w_empty  = (r_count == '0);
  assign w_pushOk = i_push & ~w_full;
  assign w_popOk  = i_pop & ~w_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_popOk)  r_rdPtr <= r_rdPtr + PTR_ONE;
      case ({w_pushOk, w_popOk})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_pushOk) r_mem[r_wrPtr] <= i_data;
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/wb_stream_port.sv
// Wishbone B4 classic responder exposing a TX byte stream and an RX byte
// stream as a DATA/STATUS register pair, each direction buffered by a FIFO.
module wb_stream_port
  import wb_stream_port_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int ADDR_WIDTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [31:0]           dat_i,
  output logic [31:0]           dat_o,
  input  logic                  we_i,
  input  logic [3:0]            sel_i,
  input  logic                  stb_i,
  input  logic                  cyc_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready
);

  logic                     r_ack;
  logic                     r_err;
  logic [31:0]              r_dat;
  logic                     r_txOvf;

  logic                     w_req;
  regIdx_e                  w_idx;
  logic                     w_mapped;
  logic                     w_txPushReq;
  logic                     w_rxPopReq;
  logic                     w_ovfClr;
  logic [31:0]              w_rdData;

  logic [7:0]               w_txHead;
  logic                     w_txFull;
  logic                     w_txEmpty;
  logic [FIFO_DEPTH_LOG2:0] w_txCount;
  logic [7:0]               w_rxHead;
  logic                     w_rxFull;
  logic                     w_rxEmpty;
  logic [FIFO_DEPTH_LOG2:0] w_rxCount;
  logic                     w_rxPush;
  logic                     w_unused;

  // A new request is taken only while no termination is showing, so a held
  // strobe alternates one busy cycle with one idle cycle.
  assign w_req    = cyc_i & stb_i & ~r_ack & ~r_err;
  assign w_idx    = regIdx_e'(adr_i[3:2]);
  assign w_mapped = (w_idx == REG_DATA) || (w_idx == REG_STATUS);

  assign w_txPushReq = w_req & we_i & (w_idx == REG_DATA) & sel_i[0];
  assign w_rxPopReq  = w_req & ~we_i & (w_idx == REG_DATA);
  assign w_ovfClr    = w_req & we_i & (w_idx == REG_STATUS) & sel_i[0] & dat_i[ST_TX_OVF];
  assign w_rxPush    = rx_valid & rx_ready;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_txFifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_txPushReq),
    .i_pop   (tx_ready),
    .i_data  (dat_i[7:0]),
    .o_head  (w_txHead),
    .o_full  (w_txFull),
    .o_empty (w_txEmpty),
    .o_count (w_txCount)
  );

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_rxFifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_rxPush),
    .i_pop   (w_rxPopReq),
    .i_data  (rx_data),
    .o_head  (w_rxHead),
    .o_full  (w_rxFull),
    .o_empty (w_rxEmpty),
    .o_count (w_rxCount)
  );

  always_comb begin
    w_rdData = '0;
    if (!we_i) begin
      case (w_idx)
        REG_DATA:   if (!w_rxEmpty) w_rdData = {23'b0, 1'b1, w_rxHead};
        REG_STATUS: w_rdData = packStatus(r_txOvf, w_txFull, w_txEmpty, ~w_rxEmpty);
        default:    w_rdData = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
      r_txOvf <= 1'b0;
    end else begin
      r_ack <= w_req & w_mapped;
      r_err <= w_req & ~w_mapped;
      r_dat <= (w_req & w_mapped) ? w_rdData : '0;
      if (w_txPushReq && w_txFull) r_txOvf <= 1'b1;
      else if (w_ovfClr)           r_txOvf <= 1'b0;
    end
  end

  // Reset masks every output immediately, which also hides an ack that was
  // already registered for a request caught by reset.
  assign ack_o    = r_ack & ~rst;
  assign err_o    = r_err & ~rst;
  assign dat_o    = rst ? '0 : r_dat;
  assign tx_valid = ~w_txEmpty & ~rst;
  assign tx_data  = w_txHead;
  assign rx_ready = ~w_rxFull & ~rst;

  assign w_unused = ^{adr_i, dat_i, sel_i, w_txCount, w_rxCount};

endmodule
